// File: rtl/wb_ctrl_if.sv
// Bundle between the main controller, the systolic array result stream and the
// output-SRAM write port, as seen by the write-back controller.
`ifndef WORD_ADDR_BITS
`define WORD_ADDR_BITS 12
`endif
`ifndef DATA_MAX_BITS
`define DATA_MAX_BITS 8
`endif

interface wb_ctrl_if #(
  parameter int unsigned DATA_W = 32
);
  // Job descriptor and handshake
  logic                        config_valid;
  logic [2:0]                  op;
  logic [`WORD_ADDR_BITS-1:0]  src_addr;
  logic [`DATA_MAX_BITS-1:0]   row;
  logic [`DATA_MAX_BITS-1:0]   col;
  logic                        ack;
  logic                        done;

  // Result stream
  logic                        res_valid;
  logic [DATA_W-1:0]           res_data;
  logic                        res_ready;

  // SRAM write port
  logic                        mem_wr_en;
  logic [`WORD_ADDR_BITS-1:0]  mem_wr_addr;
  logic [DATA_W-1:0]           mem_wr_data;
  logic                        mem_gnt;

  modport master (
    output config_valid, op, src_addr, row, col, res_valid, res_data, mem_gnt,
    input  ack, done, res_ready, mem_wr_en, mem_wr_addr, mem_wr_data
  );

  modport slave (
    input  config_valid, op, src_addr, row, col, res_valid, res_data, mem_gnt,
    output ack, done, res_ready, mem_wr_en, mem_wr_addr, mem_wr_data
  );
endinterface

// File: rtl/wb_ctrl.sv
// Write-back controller: buffers row*col result words from the systolic array in a
// small FIFO and writes them to consecutive output-SRAM addresses starting at src_addr.
`ifndef WORD_ADDR_BITS
`define WORD_ADDR_BITS 12
`endif
`ifndef DATA_MAX_BITS
`define DATA_MAX_BITS 8
`endif

module wb_ctrl #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  wb_ctrl_if.slave   bus
);

  localparam int unsigned AW = `WORD_ADDR_BITS;
  localparam int unsigned DW = `DATA_MAX_BITS;
  localparam int unsigned TW = 2 * DW;
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    RUN  = 2'd2,
    FIN  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     src_q,   src_d;
  logic [TW-1:0]     total_q, total_d;
  logic [TW-1:0]     acc_q,   acc_d;
  logic [TW-1:0]     wcnt_q,  wcnt_d;
  logic [PW-1:0]     wptr_q,  wptr_d;
  logic [PW-1:0]     rptr_q,  rptr_d;
  logic [CW-1:0]     cnt_q,   cnt_d;
  logic [DATA_W-1:0] fifo_q [FIFO_DEPTH];

  logic fifo_full;
  logic fifo_empty;
  logic push;
  logic pop;

  // Handshake and write-port outputs decoded from registered state only
  assign fifo_empty      = (cnt_q == '0);
  assign fifo_full       = (cnt_q == CW'(FIFO_DEPTH));
  assign bus.ack         = (state_q == ACK);
  assign bus.done        = (state_q == FIN);
  assign bus.res_ready   = (state_q == RUN) && !fifo_full && (acc_q < total_q);
  assign bus.mem_wr_en   = (state_q == RUN) && !fifo_empty;
  assign bus.mem_wr_addr = src_q + AW'(wcnt_q);
  assign bus.mem_wr_data = bus.mem_wr_en ? fifo_q[rptr_q] : '0;

  assign push = bus.res_valid && bus.res_ready;
  assign pop  = bus.mem_wr_en && bus.mem_gnt;

  // Next-state, counters and FIFO pointers
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    total_d = total_q;
    acc_d   = acc_q;
    wcnt_d  = wcnt_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    cnt_d   = cnt_q + CW'(push) - CW'(pop);

    if (push) begin
      wptr_d = wptr_q + PW'(1);
      acc_d  = acc_q + TW'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + PW'(1);
      wcnt_d = wcnt_q + TW'(1);
    end

    case (state_q)
      IDLE: begin
        if (bus.config_valid && (bus.op == 3'b000)) begin
          src_d   = bus.src_addr;
          total_d = TW'(bus.row) * TW'(bus.col);
          acc_d   = '0;
          wcnt_d  = '0;
          state_d = ACK;
        end
      end
      ACK:     state_d = (total_q == '0) ? FIN : RUN;
      RUN: begin
        if (wcnt_d == total_q) begin
          state_d = FIN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State registers; FIFO storage is datapath-only and needs no reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      src_q   <= '0;
      total_q <= '0;
      acc_q   <= '0;
      wcnt_q  <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      total_q <= total_d;
      acc_q   <= acc_d;
      wcnt_q  <= wcnt_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
    end
    if (push) begin
      fifo_q[wptr_q] <= bus.res_data;
    end
  end

endmodule

// File: tb/tb_wb_ctrl.sv
// Scoreboard bench for wb_ctrl: each job pushes its expected (address, data) writes,
// a negedge monitor pops and compares them as the DUT performs SRAM writes.
`ifndef WORD_ADDR_BITS
`define WORD_ADDR_BITS 12
`endif
`ifndef DATA_MAX_BITS
`define DATA_MAX_BITS 8
`endif

module tb_wb_ctrl;

  localparam int unsigned AW  = `WORD_ADDR_BITS;
  localparam int unsigned DMW = `DATA_MAX_BITS;
  localparam int unsigned DW  = 32;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_ctrl_if #(.DATA_W(DW)) bus ();

  wb_ctrl #(.DATA_W(DW), .FIFO_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  done_cnt = 0;
  int  done_cyc = 0;
  int  done_issued = 0;
  int  writes_seen = 0;
  wr_t exp_q[$];
  wr_t mon_e;
  bit  stall_q = 1'b0;
  logic [AW-1:0] stall_addr;
  logic [DW-1:0] stall_data;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops expected writes, checks stall stability and done pulses
  always @(negedge clk) begin
    if (!rst) begin
      stall_q = 1'b0;
      exp_q.delete();
    end else begin
      if (stall_q) begin
        chk("stall_en_hold", bus.mem_wr_en, 1);
        chk("stall_addr_hold", bus.mem_wr_addr, stall_addr);
        chk("stall_data_hold", bus.mem_wr_data, stall_data);
      end
      if (bus.mem_wr_en) begin
        chk("wr_en_expected", exp_q.size() > 0, 1);
        if (bus.mem_gnt && exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          chk("wr_addr", bus.mem_wr_addr, mon_e.addr);
          chk("wr_data", bus.mem_wr_data, mon_e.data);
          writes_seen++;
        end
      end
      stall_q    = bus.mem_wr_en && !bus.mem_gnt;
      stall_addr = bus.mem_wr_addr;
      stall_data = bus.mem_wr_data;
      if (bus.done) begin
        chk("done_expected", done_cnt < done_issued, 1);
        chk("done_all_written", exp_q.size(), 0);
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic idle_inputs();
    bus.config_valid = 1'b0;
    bus.op           = 3'b000;
    bus.res_valid    = 1'b0;
    bus.res_data     = '0;
    bus.mem_gnt      = 1'b0;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_ack"}, bus.ack, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_res_ready"}, bus.res_ready, 0);
    chk({tag, "_wr_en"}, bus.mem_wr_en, 0);
    chk({tag, "_wr_addr"}, bus.mem_wr_addr, 0);
    chk({tag, "_wr_data"}, bus.mem_wr_data, 0);
  endtask

  // One job: expected writes come from src + i (mod 2^AW) for i < row*col
  task automatic run_job(input int src, input int row, input int col, input int stall,
                         input int vpct, input int gpct, input bit poke,
                         input int abort_after, input int lat, input bit lat_exact,
                         input bit seq_data);
    int total;
    int idx;
    int ack_at;
    int d0;
    int d1;
    int w0;
    bit fin;
    logic [DW-1:0] words[$];
    total = row * col;
    idx   = 0;
    fin   = 1'b0;
    for (int i = 0; i < total; i++) begin
      wr_t e;
      words.push_back(seq_data ? DW'(i + 1) : DW'($urandom));
      e.addr = AW'((src + i) % (1 << AW));
      e.data = words[i];
      exp_q.push_back(e);
    end
    if (abort_after == 0) done_issued++;

    @(posedge clk); #1;
    bus.config_valid = 1'b1;
    bus.op           = 3'b000;
    bus.src_addr     = AW'(src);
    bus.row          = DMW'(row);
    bus.col          = DMW'(col);
    @(negedge clk);
    chk("ack_before_accept", bus.ack, 0);
    @(posedge clk); #1;
    bus.config_valid = 1'b0;
    @(negedge clk);
    chk("ack_pulse", bus.ack, 1);
    ack_at = cyc;
    d0     = done_cnt;
    w0     = writes_seen;

    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      if (done_cnt != d0) begin
        fin = 1'b1;
        break;
      end
      if (abort_after > 0 && (writes_seen - w0) >= abort_after) begin
        #1;
        rst = 1'b0;
        idle_inputs();
        @(posedge clk);
        @(negedge clk);
        chk_outputs_zero("abort");
        d1 = done_cnt;
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (6) @(posedge clk);
        chk("abort_no_done", done_cnt, d0);
        chk("abort_no_done_after", done_cnt, d1);
        return;
      end
      #1;
      bus.res_valid    = ($urandom_range(99) < vpct);
      bus.res_data     = (idx < total) ? words[idx] : DW'($urandom);
      bus.mem_gnt      = (c < stall) ? 1'b0 : ($urandom_range(99) < gpct);
      bus.config_valid = poke && (c == 2);
      if (poke && c == 2) begin
        bus.op       = 3'b000;
        bus.src_addr = AW'(~src);
        bus.row      = DMW'(row + 1);
        bus.col      = DMW'(col + 1);
      end
      @(negedge clk);
      if (bus.res_valid && bus.res_ready) begin
        chk("accept_within_total", idx < total, 1);
        idx++;
      end
      if (poke && (c == 2 || c == 3)) chk("ack_ignored_in_run", bus.ack, 0);
      if (stall > 0 && c == stall - 1) begin
        chk("bp_ready_low", bus.res_ready, 0);
        chk("bp_fifo_fill", idx, 4);
      end
    end
    #1;
    idle_inputs();
    chk("done_seen", fin, 1);
    chk("accepted_total", idx, total);
    if (lat > 0) begin
      if (lat_exact) chk("done_latency", done_cyc - ack_at, lat);
      else           chk("done_latency_max", (done_cyc - ack_at) <= lat, 1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst          = 1'b0;
    bus.src_addr = '0;
    bus.row      = '0;
    bus.col      = '0;
    idle_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_outputs_zero("reset");
    @(posedge clk); #1;
    rst = 1'b1;

    // Non-zero op in IDLE is ignored
    bus.config_valid = 1'b1;
    bus.op           = 3'b001;
    bus.src_addr     = AW'(12'h055);
    bus.row          = DMW'(1);
    bus.col          = DMW'(1);
    @(negedge clk);
    chk("op1_ack_now", bus.ack, 0);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    chk("op1_ack_next", bus.ack, 0);
    @(negedge clk);
    chk("op1_no_write", bus.mem_wr_en, 0);

    // Basic, back-pressure, zero size, wrap, ignore-in-run, reset mid-job, recovery
    run_job(32'h100, 2, 3, 0, 100, 100, 1'b0, 0, 8, 1'b1, 1'b1);
    run_job(32'h100, 2, 3, 10, 100, 100, 1'b0, 0, 0, 1'b0, 1'b1);
    run_job(32'h200, 0, 5, 0, 100, 100, 1'b0, 0, 2, 1'b0, 1'b0);
    run_job((1 << AW) - 2, 1, 4, 0, 100, 100, 1'b0, 0, 0, 1'b0, 1'b0);
    run_job(32'h100, 2, 3, 0, 100, 100, 1'b1, 0, 0, 1'b0, 1'b1);
    run_job(32'h100, 2, 3, 0, 100, 100, 1'b0, 3, 0, 1'b0, 1'b1);
    run_job(32'h100, 2, 3, 0, 100, 100, 1'b0, 0, 8, 1'b1, 1'b1);

    for (int j = 0; j < 12; j++) begin
      run_job(int'($urandom_range((1 << AW) - 1)), int'($urandom_range(4)),
              int'($urandom_range(4)), 0, int'($urandom_range(100, 30)),
              int'($urandom_range(100, 30)), 1'b0, 0, 0, 1'b0, 1'b0);
    end

    repeat (3) @(posedge clk);
    chk("final_done_count", done_cnt, done_issued);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
